// File: rtl/riscv_core_mdu.sv
// Iterative RV64M multiply/divide unit: shift-add multiplier, restoring radix-2 divider.
// Define MDU_FAST_MUL_EN to compute multiplies with a single-cycle multiplier in IDLE.
module riscv_core_mdu #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned CNT_W = 7
) (
    input  logic            i_mdu_clk,
    input  logic            i_mdu_rst,
    input  logic            i_mdu_start,
    input  logic            i_mdu_kill,
    input  logic [2:0]      i_mdu_op,
    input  logic            i_mdu_word,
    input  logic [XLEN-1:0] i_mdu_srca,
    input  logic [XLEN-1:0] i_mdu_srcb,
    output logic [XLEN-1:0] o_mdu_result,
    output logic            o_mdu_busy,
    output logic            o_mdu_done
);

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

`ifdef MDU_FAST_MUL_EN
    localparam bit FastMul = 1'b1;
`else
    localparam bit FastMul = 1'b0;
`endif

    state_e            r_state, w_state_next;
    logic [2:0]        r_op;
    logic              r_word;
    logic [CNT_W-1:0]  r_cnt;
    logic [XLEN-1:0]   r_a, r_b, r_rem, r_result;
    logic [2*XLEN-1:0] r_acc;
    logic              r_neg_q, r_neg_r;

    function automatic logic [XLEN-1:0] f_sext32(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction

    function automatic logic [XLEN-1:0] f_mul_out(input logic [2*XLEN-1:0] p, input logic neg,
                                                  input logic [2:0] op, input logic word);
        logic [2*XLEN-1:0] s;
        s = neg ? -p : p;
        if (word) return f_sext32(s[31:0]);
        if (op[1:0] == 2'b00) return s[XLEN-1:0];
        return s[2*XLEN-1:XLEN];
    endfunction

    function automatic logic [XLEN-1:0] f_div_out(input logic [XLEN-1:0] q, input logic [XLEN-1:0] r,
                                                  input logic neg_q, input logic neg_r,
                                                  input logic is_rem, input logic word);
        logic [XLEN-1:0] v;
        v = is_rem ? (neg_r ? -r : r) : (neg_q ? -q : q);
        return word ? f_sext32(v[31:0]) : v;
    endfunction

    logic            w_go, w_is_div, w_a_signed, w_b_signed, w_a_neg, w_b_neg;
    logic            w_b_zero, w_ovf, w_special;
    logic [XLEN-1:0] w_a_ext, w_b_ext, w_a_mag, w_b_mag, w_min, w_special_res;

    // Operand conditioning; MUL and all word multiplies need only the low bits, so stay unsigned
    always_comb begin
        w_go       = i_mdu_start && !i_mdu_kill;
        w_is_div   = i_mdu_op[2];
        w_a_signed = w_is_div ? !i_mdu_op[0]
                              : (!i_mdu_word && (i_mdu_op == 3'b001 || i_mdu_op == 3'b010));
        w_b_signed = w_is_div ? !i_mdu_op[0] : (!i_mdu_word && i_mdu_op == 3'b001);
        if (i_mdu_word) begin
            w_a_ext = w_a_signed ? f_sext32(i_mdu_srca[31:0])
                                 : {{(XLEN-32){1'b0}}, i_mdu_srca[31:0]};
            w_b_ext = w_b_signed ? f_sext32(i_mdu_srcb[31:0])
                                 : {{(XLEN-32){1'b0}}, i_mdu_srcb[31:0]};
            w_min   = f_sext32(32'h8000_0000);
        end else begin
            w_a_ext = i_mdu_srca;
            w_b_ext = i_mdu_srcb;
            w_min   = {1'b1, {(XLEN-1){1'b0}}};
        end
        w_a_neg   = w_a_signed && w_a_ext[XLEN-1];
        w_b_neg   = w_b_signed && w_b_ext[XLEN-1];
        w_a_mag   = w_a_neg ? -w_a_ext : w_a_ext;
        w_b_mag   = w_b_neg ? -w_b_ext : w_b_ext;
        w_b_zero  = (w_b_ext == '0);
        w_ovf     = w_a_signed && (w_a_ext == w_min) && (&w_b_ext);
        w_special = w_is_div && (w_b_zero || w_ovf);
        if (w_b_zero) begin
            w_special_res = i_mdu_op[1] ? (i_mdu_word ? f_sext32(i_mdu_srca[31:0]) : i_mdu_srca)
                                        : '1;
        end else begin
            w_special_res = i_mdu_op[1] ? '0 : w_a_ext;
        end
    end

`ifdef MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] w_fast_prod;
    assign w_fast_prod = {{XLEN{1'b0}}, w_a_mag} * {{XLEN{1'b0}}, w_b_mag};
`endif

    logic [XLEN:0]     w_sum, w_shift;
    logic [XLEN-1:0]   w_sub, w_fix;
    logic              w_ge;
    logic [2*XLEN-1:0] w_prod;

    always_comb begin
        w_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, (r_acc[0] ? r_a : {XLEN{1'b0}})};
        w_shift = {r_rem, r_acc[XLEN-1]};
        w_ge    = w_shift >= {1'b0, r_b};
        w_sub   = w_shift[XLEN-1:0] - r_b;
        // A 32-step multiply leaves the product 32 bits above its 64-step position
        w_prod  = r_word ? {32'b0, r_acc[2*XLEN-1:32]} : r_acc;
        w_fix   = r_op[2] ? f_div_out(r_acc[XLEN-1:0], r_rem, r_neg_q, r_neg_r, r_op[1], r_word)
                          : f_mul_out(w_prod, r_neg_q, r_op, r_word);
    end

    always_ff @(posedge i_mdu_clk or posedge i_mdu_rst) begin
        if (i_mdu_rst) r_state <= StIdle;
        else           r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: if (w_go) w_state_next = (w_special || (FastMul && !w_is_div)) ? StDone : StCalc;
            StCalc: begin
                if (i_mdu_kill)                 w_state_next = StIdle;
                else if (r_cnt == CNT_W'(1))    w_state_next = StFix;
            end
            StFix:   w_state_next = i_mdu_kill ? StIdle : StDone;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_mdu_clk or posedge i_mdu_rst) begin
        if (i_mdu_rst) begin
            r_op     <= '0;
            r_word   <= 1'b0;
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_rem    <= '0;
            r_acc    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                StIdle: if (w_go) begin
                    r_op    <= i_mdu_op;
                    r_word  <= i_mdu_word;
                    r_cnt   <= i_mdu_word ? CNT_W'(32) : CNT_W'(XLEN);
                    r_a     <= w_a_mag;
                    r_b     <= w_b_mag;
                    r_neg_q <= w_a_neg ^ w_b_neg;
                    r_neg_r <= w_a_neg;
                    r_rem   <= '0;
                    // Word divides place the dividend at the top so the MSB shift-out is uniform
                    r_acc   <= w_is_div
                        ? {{XLEN{1'b0}}, (i_mdu_word ? {w_a_mag[31:0], {(XLEN-32){1'b0}}} : w_a_mag)}
                        : {{XLEN{1'b0}}, w_b_mag};
                    if (w_special) r_result <= w_special_res;
`ifdef MDU_FAST_MUL_EN
                    else if (!w_is_div)
                        r_result <= f_mul_out(w_fast_prod, w_a_neg ^ w_b_neg, i_mdu_op, i_mdu_word);
`endif
                end
                StCalc: if (!i_mdu_kill) begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_op[2]) begin
                        r_rem             <= w_ge ? w_sub : w_shift[XLEN-1:0];
                        r_acc[XLEN-1:0]   <= {r_acc[XLEN-2:0], w_ge};
                    end else begin
                        r_acc <= {w_sum, r_acc[XLEN-1:1]};
                    end
                end
                StFix: if (!i_mdu_kill) r_result <= w_fix;
                default: ;
            endcase
        end
    end

    assign o_mdu_busy   = (r_state == StIdle) ? w_go : 1'b1;
    assign o_mdu_done   = (r_state == StDone);
    assign o_mdu_result = r_result;

endmodule
